out_set_wr_arb: RTL and testbench
=================================

OUT_SET_WR_ARB -- requirements
Module: out_set_wr_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 1, number of implemented setting registers; legal addresses are 0..DEPTH-1, DEPTH 1..16.
- SETUP_CYC, 1, cycles CS/WE/addr/data are valid before the strobe rises, minimum 1.
- STROBE_CYC, 1, strobe high width in cycles, minimum 1.
- HOLD_CYC, 1, cycles CS/WE/addr/data are held after the strobe falls, minimum 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK  in  1  single clock; all logic on its rising edge.
- CLEAR  in  1  reset, synchronous, active-high.
- req_a / req_b  in  1  write request from requester A / B.
- addr_a / addr_b  in  4  target register address.
- data_a / data_b  in  8  write data.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- err_a / err_b  out  1  one-cycle pulse coincident with ack: address out of range.
- write_data_strob  out  1  write strobe to the register bank; the bank captures on its rising edge.
- addr  out  4  bank address.
- data_out  out  8  bank write data.
- WE  out  1  active-low write enable.
- CS  out  1  active-low chip select.
- busy  out  1  high in any state other than IDLE.
REQ-003 Every output SHALL be driven from a register; there are no combinational input-to-output paths.

Function
REQ-004 FSM states SHALL be IDLE, SETUP, STROBE, HOLD and DONE; there is one down-counter shared by the timed states.
REQ-005 In IDLE with at least one request high, the block SHALL grant a requester and latch its addr and data into addr and data_out.
- Next state is SETUP if the address is below DEPTH, else DONE with err set.
REQ-006 Arbitration SHALL be round-robin.
- With both requests high, the grant goes to the requester not served last.
- After CLEAR, A has priority.
- A lone request is granted immediately.
REQ-007 SETUP SHALL assert CS=0, WE=0 and write_data_strob=0 for exactly SETUP_CYC cycles, then move to STROBE.
REQ-008 STROBE SHALL hold write_data_strob=1 with CS=0 and WE=0 for exactly STROBE_CYC cycles, then move to HOLD.
REQ-009 HOLD SHALL hold write_data_strob=0 with CS=0 and WE=0 for exactly HOLD_CYC cycles, then move to DONE.
REQ-010 DONE SHALL last one cycle, then return to IDLE.
- It drives CS=1, WE=1, write_data_strob=0.
- It pulses the granted requester's ack, and its err if the address was illegal.
- addr and data_out keep their last values.
REQ-011 addr and data_out SHALL remain constant from SETUP entry through the end of HOLD.
- Input changes after the grant are ignored.
REQ-012 Latency SHALL be fixed.
- Request sampled in IDLE at edge k: SETUP occupies cycles k+1..k+S, where S=SETUP_CYC.
- The strobe rises at k+S+1.
- ack is high in cycle k+S+P+H+1, where P=STROBE_CYC and H=HOLD_CYC.
- For an illegal address, ack and err are high in cycle k+1 and CS never goes low.
REQ-013 After DONE the block SHALL pass through at least one IDLE cycle before the next grant.
- A request held continuously therefore produces a new transaction every S+P+H+2 cycles.
REQ-014 A requester SHALL keep req high until its ack.
- Dropping req after the grant does not abort the transaction.
- Dropping req before the grant withdraws it.
REQ-015 Exactly one write_data_strob rising edge SHALL occur per legal transaction, and none for illegal ones.
REQ-016 The counter SHALL be wide enough for the largest of SETUP_CYC, STROBE_CYC and HOLD_CYC, with no wrap-around.

Reset
REQ-017 CLEAR sampled high SHALL force, at that edge, the following values:
- state IDLE, counter 0, round-robin pointer to A;
- CS=1, WE=1, write_data_strob=0;
- addr=0, data_out=0;
- all ack and err outputs 0, busy=0.
REQ-018 CLEAR asserted mid-transaction SHALL abort it without an ack.
- The strobe drops at the same edge.
- A strobe already risen is not repeated after reset.
REQ-019 CLEAR SHALL take priority over every request, and requests are ignored while it is high.

Verification
REQ-020 Single write, default parameters: req_a=1, addr_a=0, data_a=8'hA5 sampled at edge k.
- CS=0 and WE=0 in cycles k+1..k+3, strobe high in cycle k+2 only.
- addr=0 and data_out=A5 throughout; ack_a in cycle k+4; err_a=0.
REQ-021 Contention, DEPTH=5: req_a and req_b high together after reset, addr 1 and 2.
- A is served first, then B (ack_b 5 cycles after ack_a).
- A third simultaneous request afterwards is granted to A.
REQ-022 Illegal address, DEPTH=5: req_b with addr_b=7.
- ack_b and err_b pulse in the cycle after the grant; CS stays 1 and no strobe edge occurs.
REQ-023 Timing parameters SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2.
- Strobe high exactly 3 cycles and starts 2 cycles after CS falls.
- ack arrives 8 cycles after the grant edge.
REQ-024 Reset mid-strobe: CLEAR during STROBE.
- Next cycle: CS=1, WE=1, strobe=0, busy=0, no ack.
- A pending req_b is served normally after CLEAR falls.

Source files
------------

// File: rtl/out_set_wr_arb.sv
// Two-requester round-robin write arbiter driving a register bank with
// programmable setup / strobe / hold timing; every output is registered.
module out_set_wr_arb #(
  parameter int DEPTH      = 1,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err_a,
  output logic       err_b,
  output logic       write_data_strob,
  output logic [3:0] addr,
  output logic [7:0] data_out,
  output logic       WE,
  output logic       CS,
  output logic       busy
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [4:0]    DEPTH_LIM = 5'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          prio_a;
  logic          owner_b, next_owner_b;
  logic          bad_addr, next_bad;
  logic          grant, grant_b;
  logic [3:0]    sel_addr;
  logic [7:0]    sel_data;
  logic          timed;

  // Counter holds "cycles remaining minus one" in each timed state.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    grant      = 1'b0;
    grant_b    = 1'b0;
    sel_addr   = addr_a;
    sel_data   = data_a;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          grant    = 1'b1;
          grant_b  = req_b && (!req_a || !prio_a);
          sel_addr = grant_b ? addr_b : addr_a;
          sel_data = grant_b ? data_b : data_a;
          if ({1'b0, sel_addr} < DEPTH_LIM) begin
            next_state = SETUP;
            next_cnt   = SETUP_LD;
          end else begin
            next_state = DONE;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          next_state = STROBE;
          next_cnt   = STROBE_LD;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          next_state = HOLD;
          next_cnt   = HOLD_LD;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          next_state = DONE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    next_owner_b = grant ? grant_b : owner_b;
    next_bad     = grant ? (next_state == DONE) : bad_addr;
    timed        = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state            <= IDLE;
      cnt              <= '0;
      prio_a           <= 1'b1;
      owner_b          <= 1'b0;
      bad_addr         <= 1'b0;
      addr             <= '0;
      data_out         <= '0;
      CS               <= 1'b1;
      WE               <= 1'b1;
      write_data_strob <= 1'b0;
      busy             <= 1'b0;
      ack_a            <= 1'b0;
      ack_b            <= 1'b0;
      err_a            <= 1'b0;
      err_b            <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      owner_b  <= next_owner_b;
      bad_addr <= next_bad;
      if (grant) begin
        prio_a   <= grant_b;
        addr     <= sel_addr;
        data_out <= sel_data;
      end
      CS               <= !timed;
      WE               <= !timed;
      write_data_strob <= (next_state == STROBE);
      busy             <= (next_state != IDLE);
      ack_a            <= (next_state == DONE) && !next_owner_b;
      ack_b            <= (next_state == DONE) && next_owner_b;
      err_a            <= (next_state == DONE) && !next_owner_b && next_bad;
      err_b            <= (next_state == DONE) && next_owner_b && next_bad;
    end
  end

endmodule

// File: tb/tb_out_set_wr_arb.sv
// Directed bench: dut_d uses default timing, dut_t uses 2/3/2 timing; both DEPTH=5.
// Status vectors are {CS, WE, strobe, ack_a, err_a, ack_b, err_b, busy}.
module tb_out_set_wr_arb;

  logic       CLK = 1'b0;
  logic       CLEAR = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0;
  logic [7:0] data_a = '0, data_b = '0;

  logic       ack_a_d, ack_b_d, err_a_d, err_b_d, strb_d, we_d, cs_d, busy_d;
  logic [3:0] addr_d;
  logic [7:0] data_d;
  logic       ack_a_t, ack_b_t, err_a_t, err_b_t, strb_t, we_t, cs_t, busy_t;
  logic [3:0] addr_t;
  logic [7:0] data_t;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] seq[$];

  always #5 CLK = ~CLK;

  out_set_wr_arb #(.DEPTH(5)) dut_d (
    .CLK(CLK), .CLEAR(CLEAR), .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a_d), .ack_b(ack_b_d), .err_a(err_a_d), .err_b(err_b_d),
    .write_data_strob(strb_d), .addr(addr_d), .data_out(data_d),
    .WE(we_d), .CS(cs_d), .busy(busy_d));

  out_set_wr_arb #(.DEPTH(5), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_t (
    .CLK(CLK), .CLEAR(CLEAR), .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a_t), .ack_b(ack_b_t), .err_a(err_a_t), .err_b(err_b_t),
    .write_data_strob(strb_t), .addr(addr_t), .data_out(data_t),
    .WE(we_t), .CS(cs_t), .busy(busy_t));

  wire [7:0] obs_d = {cs_d, we_d, strb_d, ack_a_d, err_a_d, ack_b_d, err_b_d, busy_d};
  wire [7:0] obs_t = {cs_t, we_t, strb_t, ack_a_t, err_a_t, ack_b_t, err_b_t, busy_t};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic ra, input logic [3:0] aa, input logic [7:0] da,
                               input logic rb, input logic [3:0] ab, input logic [7:0] db);
    req_a  = ra;
    addr_a = aa;
    data_a = da;
    req_b  = rb;
    addr_b = ab;
    data_b = db;
  endtask

  task automatic clearDut();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
  endtask

  // Checks one status vector per cycle from seq, advancing a cycle after each.
  task automatic runSeq(input string tag, input bit slow);
    for (int i = 0; i < seq.size(); i++) begin
      checkOutput($sformatf("%s_c%0d", tag, i + 1), 32'(slow ? obs_t : obs_d), 32'(seq[i]));
      step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step();
    checkOutput("reset_status_d", 32'(obs_d), 32'h00C0);
    checkOutput("reset_status_t", 32'(obs_t), 32'h00C0);
    checkOutput("reset_addr", 32'(addr_d), 32'h0);
    checkOutput("reset_data", 32'(data_d), 32'h0);
    CLEAR = 1'b0;

    // Single write; inputs scrambled right after the grant must not leak through.
    applyStimulus(1'b1, 4'd0, 8'hA5, 1'b0, 4'd0, 8'h00);
    step();
    applyStimulus(1'b0, 4'd3, 8'h3C, 1'b0, 4'd0, 8'h00);
    checkOutput("single_addr", 32'(addr_d), 32'h0);
    checkOutput("single_data", 32'(data_d), 32'hA5);
    seq = '{8'h01, 8'h21, 8'h01, 8'hD1, 8'hC0};
    runSeq("single", 1'b0);
    checkOutput("single_data_kept", 32'(data_d), 32'hA5);

    // Contention: A, then B, then A again while both stay asserted.
    clearDut();
    applyStimulus(1'b1, 4'd1, 8'h11, 1'b1, 4'd2, 8'h22);
    step();
    checkOutput("cont_addr_a", 32'(addr_d), 32'h1);
    seq = '{8'h01, 8'h21, 8'h01, 8'hD1, 8'hC0, 8'h01};
    runSeq("cont_a", 1'b0);
    checkOutput("cont_addr_b", 32'(addr_d), 32'h2);
    checkOutput("cont_data_b", 32'(data_d), 32'h22);
    seq = '{8'h21, 8'h01, 8'hC5, 8'hC0, 8'h01, 8'h21, 8'h01, 8'hD1};
    runSeq("cont_b_a", 1'b0);
    checkOutput("cont_addr_a2", 32'(addr_d), 32'h1);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    step();

    // Illegal addresses above and at DEPTH, then the last legal address.
    clearDut();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h77);
    step();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    checkOutput("illegal_b_addr", 32'(addr_d), 32'h7);
    checkOutput("illegal_b_slow", 32'(obs_t), 32'h00C7);
    seq = '{8'hC7, 8'hC0};
    runSeq("illegal_b", 1'b0);
    applyStimulus(1'b1, 4'd5, 8'h55, 1'b0, 4'd0, 8'h00);
    step();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    seq = '{8'hD9, 8'hC0};
    runSeq("illegal_a5", 1'b0);
    applyStimulus(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00);
    step();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    seq = '{8'h01, 8'h21, 8'h01, 8'hD1, 8'hC0};
    runSeq("legal_a4", 1'b0);

    // Stretched timing on the 2/3/2 instance.
    clearDut();
    applyStimulus(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00);
    step();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    seq = '{8'h01, 8'h01, 8'h21, 8'h21, 8'h21, 8'h01, 8'h01, 8'hD1, 8'hC0};
    runSeq("timing", 1'b1);
    checkOutput("timing_addr", 32'(addr_t), 32'h3);
    checkOutput("timing_data", 32'(data_t), 32'h5A);

    // Reset during the strobe aborts A; pending B runs afterwards.
    clearDut();
    applyStimulus(1'b1, 4'd0, 8'h0F, 1'b1, 4'd4, 8'h44);
    step();
    checkOutput("abort_setup", 32'(obs_d), 32'h0001);
    step();
    checkOutput("abort_strobe", 32'(obs_d), 32'h0021);
    CLEAR = 1'b1;
    step();
    checkOutput("abort_status", 32'(obs_d), 32'h00C0);
    checkOutput("abort_addr", 32'(addr_d), 32'h0);
    checkOutput("abort_data", 32'(data_d), 32'h0);
    CLEAR = 1'b0;
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h44);
    step();
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    seq = '{8'h01, 8'h21, 8'h01, 8'hC5, 8'hC0};
    runSeq("after_abort_b", 1'b0);
    checkOutput("after_abort_addr", 32'(addr_d), 32'h4);
    checkOutput("after_abort_data", 32'(data_d), 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
